// File: rtl/sd_write_stream_dat.sv
// SDIO slave 4-bit DAT transmitter: serialises one data block (start nibble,
// payload, per-line CRC16, end nibble) from a show-ahead TX FIFO onto DAT[3:0].

module sd_crc16 (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        enable,
  input  logic        in,
  output logic [15:0] crc
);

  // x^16 + x^12 + x^5 + 1, MSB shifted out first
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      crc <= 16'h0000;
    else if (clear)
      crc <= 16'h0000;
    else if (enable)
      crc <= {crc[14:0], 1'b0} ^ ({16{in ^ crc[15]}} & 16'h1021);
  end

endmodule

module sd_write_stream_dat #(
  parameter int unsigned PREAMBLE_CLOCKS = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sd_clock,
  input  logic       write_strobe,
  input  logic [8:0] data_count,
  input  logic [7:0] byte_in,
  input  logic       fifo_empty,
  output logic       byte_read_strobe,
  output logic [3:0] sd_data_out,
  output logic       sd_data_oe,
  output logic       busy,
  output logic       write_all_strobe,
  output logic       underflow
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_START,
    S_DATA,
    S_CRC,
    S_END,
    S_RELEASE
  } state_t;

  state_t      state;
  logic        sd_clock1, sd_clock2, sd_clock3;
  logic        fall;
  logic [8:0]  data_count_buf;
  logic        nib_hi;
  logic [7:0]  byte_sh;
  logic [3:0]  crc_idx;
  logic [3:0]  pre_cnt;
  logic [3:0]  data_nib;
  logic [3:0]  crc_bits;
  logic        crc_clear;
  logic        crc_en;
  logic [15:0] crc [4];

  // sd_clock1/2 form the synchroniser; sd_clock3 is the delayed copy for edge detect
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sd_clock1 <= 1'b1;
      sd_clock2 <= 1'b1;
      sd_clock3 <= 1'b1;
    end else begin
      sd_clock1 <= sd_clock;
      sd_clock2 <= sd_clock1;
      sd_clock3 <= sd_clock2;
    end
  end

  assign fall = sd_clock3 & ~sd_clock2;

  // Nibble going onto the bus at this DATA fall; the CRCs see the same value
  always_comb begin
    data_nib = byte_sh[3:0];
    if (nib_hi)
      data_nib = fifo_empty ? 4'h0 : byte_in[7:4];
  end

  assign crc_clear = write_strobe && (state == S_IDLE);
  assign crc_en    = fall && (state == S_DATA);

  for (genvar i = 0; i < 4; i++) begin : g_crc
    sd_crc16 u_crc (
      .clock  (clock),
      .reset  (reset),
      .clear  (crc_clear),
      .enable (crc_en),
      .in     (data_nib[i]),
      .crc    (crc[i])
    );
    assign crc_bits[i] = crc[i][crc_idx];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= S_IDLE;
      sd_data_out      <= 4'hF;
      sd_data_oe       <= 1'b0;
      byte_read_strobe <= 1'b0;
      write_all_strobe <= 1'b0;
      busy             <= 1'b0;
      underflow        <= 1'b0;
      data_count_buf   <= 9'd0;
      nib_hi           <= 1'b0;
      byte_sh          <= 8'h00;
      crc_idx          <= 4'd0;
      pre_cnt          <= 4'd0;
    end else begin
      byte_read_strobe <= 1'b0;
      write_all_strobe <= 1'b0;
      case (state)
        S_IDLE: begin
          // A fall coinciding with the strobe is deliberately ignored here
          if (write_strobe) begin
            underflow <= 1'b0;
            if (data_count != 9'd0) begin
              data_count_buf <= data_count;
              busy           <= 1'b1;
              pre_cnt        <= PREAMBLE_CLOCKS[3:0];
              state          <= S_PREAMBLE;
            end else begin
              write_all_strobe <= 1'b1;
            end
          end
        end
        S_PREAMBLE: if (fall) begin
          sd_data_oe  <= 1'b1;
          sd_data_out <= 4'hF;
          pre_cnt     <= pre_cnt - 4'd1;
          if (pre_cnt == 4'd1)
            state <= S_START;
        end
        S_START: if (fall) begin
          sd_data_out <= 4'h0;
          nib_hi      <= 1'b1;
          state       <= S_DATA;
        end
        S_DATA: if (fall) begin
          sd_data_out <= data_nib;
          nib_hi      <= ~nib_hi;
          if (nib_hi) begin
            if (fifo_empty) begin
              byte_sh   <= 8'h00;
              underflow <= 1'b1;
            end else begin
              byte_sh          <= byte_in;
              byte_read_strobe <= 1'b1;
            end
          end else begin
            data_count_buf <= data_count_buf - 9'd1;
            if (data_count_buf == 9'd1) begin
              crc_idx <= 4'd15;
              state   <= S_CRC;
            end
          end
        end
        S_CRC: if (fall) begin
          sd_data_out <= crc_bits;
          crc_idx     <= crc_idx - 4'd1;
          if (crc_idx == 4'd0)
            state <= S_END;
        end
        S_END: if (fall) begin
          sd_data_out <= 4'hF;
          state       <= S_RELEASE;
        end
        S_RELEASE: if (fall) begin
          sd_data_oe       <= 1'b0;
          busy             <= 1'b0;
          write_all_strobe <= 1'b1;
          state            <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_write_stream_dat.sv
// Scoreboard bench for sd_write_stream_dat: expected DAT nibbles and FIFO pops
// are queued at stimulus time and consumed by independent monitors.

module tb_sd_write_stream_dat;

  localparam int P = 1;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       sd_clock = 1'b1;
  logic       write_strobe = 1'b0;
  logic [8:0] data_count = 9'd0;
  logic [7:0] byte_in;
  logic       fifo_empty;
  logic       byte_read_strobe;
  logic [3:0] sd_data_out;
  logic       sd_data_oe;
  logic       busy;
  logic       write_all_strobe;
  logic       underflow;

  sd_write_stream_dat #(.PREAMBLE_CLOCKS(P)) dut (
    .clock            (clock),
    .reset            (reset),
    .sd_clock         (sd_clock),
    .write_strobe     (write_strobe),
    .data_count       (data_count),
    .byte_in          (byte_in),
    .fifo_empty       (fifo_empty),
    .byte_read_strobe (byte_read_strobe),
    .sd_data_out      (sd_data_out),
    .sd_data_oe       (sd_data_oe),
    .busy             (busy),
    .write_all_strobe (write_all_strobe),
    .underflow        (underflow)
  );

  always #5 clock = ~clock;
  always #40 sd_clock = ~sd_clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Show-ahead FIFO model: main process loads, pop process advances fifo_rd
  logic [7:0] fifo_mem [0:2047];
  int fifo_wr = 0;
  int fifo_rd = 0;
  assign fifo_empty = (fifo_rd == fifo_wr);
  assign byte_in    = fifo_empty ? 8'h00 : fifo_mem[fifo_rd];

  logic [3:0] exp_nib[$];
  logic [3:0] exp_hi[$];
  logic [7:0] blk[$];
  int oe_falls = 0;
  int rd_cnt   = 0;
  int done_cnt = 0;

  // Host side samples DAT on rising sd_clock, well after the slave update
  always @(posedge sd_clock) begin
    if (sd_data_oe === 1'b1) begin
      oe_falls++;
      if (exp_nib.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dat_extra actual=%0h required=none", sd_data_out);
      end else begin
        check("dat_nib", sd_data_out, exp_nib.pop_front());
      end
    end
  end

  always @(negedge clock) begin
    if (write_all_strobe === 1'b1) done_cnt++;
    if (byte_read_strobe === 1'b1) begin
      rd_cnt++;
      if (exp_hi.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_extra actual=%0h required=none", sd_data_out);
      end else begin
        check("rd_hi_nib", sd_data_out, exp_hi.pop_front());
      end
      fifo_rd++;
    end
  end

  int snap_oe, snap_rd, snap_done;

  // Loads FIFO with the first avail bytes of blk, queues expectations, strobes
  task automatic launch(input int n, input int avail);
    logic [15:0] r [4];
    logic [7:0]  b;
    logic        top;
    exp_nib.delete();
    exp_hi.delete();
    for (int k = 0; k < avail; k++) fifo_mem[fifo_rd + k] = blk[k];
    fifo_wr = fifo_rd + avail;
    for (int k = 0; k < 4; k++) r[k] = 16'h0000;
    for (int k = 0; k < P; k++) exp_nib.push_back(4'hF);
    exp_nib.push_back(4'h0);
    for (int k = 0; k < n; k++) begin
      b = (k < avail) ? blk[k] : 8'h00;
      exp_nib.push_back(b[7:4]);
      exp_nib.push_back(b[3:0]);
      if (k < avail) exp_hi.push_back(b[7:4]);
      // Augmented-message long division: message bits shifted in, then 16 zeros
      for (int h = 1; h >= 0; h--)
        for (int ln = 0; ln < 4; ln++) begin
          top   = r[ln][15];
          r[ln] = {r[ln][14:0], b[h*4 + ln]};
          if (top) r[ln] = r[ln] ^ 16'h1021;
        end
    end
    for (int z = 0; z < 16; z++)
      for (int ln = 0; ln < 4; ln++) begin
        top   = r[ln][15];
        r[ln] = {r[ln][14:0], 1'b0};
        if (top) r[ln] = r[ln] ^ 16'h1021;
      end
    for (int k = 15; k >= 0; k--)
      exp_nib.push_back({r[3][k], r[2][k], r[1][k], r[0][k]});
    exp_nib.push_back(4'hF);
    snap_oe   = oe_falls;
    snap_rd   = rd_cnt;
    snap_done = done_cnt;
    @(negedge clock);
    data_count   = n[8:0];
    write_strobe = 1'b1;
    @(negedge clock);
    write_strobe = 1'b0;
    check("busy_rise", busy, 1);
    check("underflow_clear", underflow, 0);
  endtask

  task automatic finish_block(input string name, input int n, input int avail);
    int bound = (P + 2*n + 24) * 8 + 60;
    for (int c = 0; c < bound && done_cnt == snap_done; c++) @(negedge clock);
    check({name, "_done_timeout"}, done_cnt - snap_done, 1);
    check({name, "_busy_low"}, busy, 0);
    check({name, "_oe_falls"}, oe_falls - snap_oe, P + 2*n + 18);
    check({name, "_rd_count"}, rd_cnt - snap_rd, avail);
    check({name, "_nib_left"}, exp_nib.size(), 0);
    check({name, "_underflow"}, underflow, (avail < n) ? 1 : 0);
    repeat (40) @(negedge clock);
    check({name, "_one_done"}, done_cnt - snap_done, 1);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check("rst_dat", sd_data_out, 4'hF);
    check("rst_oe", sd_data_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_underflow", underflow, 0);
    check("rst_rd", byte_read_strobe, 0);
    check("rst_done", write_all_strobe, 0);
    reset = 1'b0;
    repeat (5) @(negedge clock);

    blk = '{8'h00};
    launch(1, 1);
    finish_block("zero1", 1, 1);

    blk = '{8'hA5, 8'h3C};
    launch(2, 2);
    finish_block("a53c", 2, 2);

    // Zero-length block: completion pulse only, bus untouched
    snap_oe = oe_falls;
    snap_done = done_cnt;
    @(negedge clock);
    data_count   = 9'd0;
    write_strobe = 1'b1;
    @(negedge clock);
    write_strobe = 1'b0;
    check("zero_len_done", write_all_strobe, 1);
    check("zero_len_busy", busy, 0);
    repeat (60) @(negedge clock);
    check("zero_len_oe", oe_falls - snap_oe, 0);
    check("zero_len_pulses", done_cnt - snap_done, 1);

    blk = '{8'h11, 8'h22, 8'h33};
    launch(3, 2);
    finish_block("under", 3, 2);
    repeat (50) @(negedge clock);
    check("under_sticky", underflow, 1);

    blk.delete();
    for (int k = 0; k < 511; k++) blk.push_back(8'($urandom_range(0, 255)));
    launch(511, 511);
    finish_block("max511", 511, 511);

    // Abort inside the CRC field, then a clean block
    blk = '{8'hC3};
    launch(1, 1);
    for (int c = 0; c < 400 && (oe_falls - snap_oe) < P + 1 + 2 + 5; c++) @(negedge clock);
    check("crc_reach_timeout", ((oe_falls - snap_oe) >= P + 8) ? 1 : 0, 1);
    reset = 1'b1;
    #1;
    check("abort_oe", sd_data_oe, 0);
    check("abort_dat", sd_data_out, 4'hF);
    check("abort_busy", busy, 0);
    exp_nib.delete();
    exp_hi.delete();
    repeat (4) @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    blk = '{8'h5A};
    launch(1, 1);
    finish_block("after_rst", 1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
